sync_fifo_ctrl: RTL and testbench

Parametrised synchronous FIFO with a full-capacity pointer scheme, occupancy count, programmable almost-full/almost-empty thresholds and a registered read port with a valid strobe. It is the general-purpose buffering block between producer and consumer logic in one clock domain, and is intended for stream buffers and command queues. Storage sits in a separate simple dual-port memory sub-module.

---
 rtl/sync_fifo_pkg.sv | 39 +++
 rtl/sync_fifo_mem.sv | 39 +++
 rtl/sync_fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo_ctrl block: address-width helper,
// status-flag struct, and parameter legality checks.
package sync_fifo_pkg;

  localparam int MIN_DEPTH = 4;
  localparam int MIN_WIDTH = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit fifo_params_ok(input int depth, input int width,
                                        input int afull_th, input int aempty_th);
    bit ok;
    ok = (width >= MIN_WIDTH);
    ok = ok && (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
    ok = ok && (afull_th >= 1) && (afull_th <= depth);
    ok = ok && (aempty_th >= 0) && (aempty_th <= depth - 1);
    return ok;
  endfunction

  function automatic fifo_flags_t calc_flags(input int cnt, input int depth,
                                             input int afull_th, input int aempty_th);
    fifo_flags_t f;
    f.full         = (cnt == depth);
    f.empty        = (cnt == 0);
    f.almost_full  = (cnt >= afull_th);
    f.almost_empty = (cnt <= aempty_th);
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for sync_fifo_ctrl: synchronous write, registered
// synchronous read that holds its last value when re is low. Contents are not reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = fifo_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: wrap-bit pointers, occupancy count, registered flags
// and 1-cycle read port. Macro SYNC_FIFO_ERR_FLAGS_EN makes overflow/underflow sticky.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  localparam int AW = fifo_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam int CW = AW + 1;
  localparam fifo_flags_t RESET_FLAGS = calc_flags(0, DEPTH, AFULL_TH, AEMPTY_TH);

  if (!fifo_params_ok(DEPTH, WIDTH, AFULL_TH, AEMPTY_TH)) begin : g_param_check
    $error("sync_fifo_ctrl: illegal DEPTH/WIDTH/threshold parameters");
  end

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]  count_q, count_d;
  fifo_flags_t  flags_q, flags_d;
  logic         rd_valid_q, rd_valid_d;
  logic         rd_seen_q, rd_seen_d;
  logic         overflow_q, overflow_d;
  logic         underflow_q, underflow_d;
  logic         wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  assign wr_acc = wr_en & ~flags_q.full;
  assign rd_acc = rd_en & ~flags_q.empty;

  // Flags come from the next count so they line up with count in the same cycle.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_acc;
    rd_seen_d   = rd_seen_q | rd_acc;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    flags_d = calc_flags(int'(count_d), DEPTH, AFULL_TH, AEMPTY_TH);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    overflow_d  = overflow_q  | (wr_en & flags_q.full);
    underflow_d = underflow_q | (rd_en & flags_q.empty);
`else
    overflow_d  = wr_en & flags_q.full;
    underflow_d = rd_en & flags_q.empty;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flags_q     <= RESET_FLAGS;
      rd_valid_q  <= 1'b0;
      rd_seen_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      rd_valid_q  <= rd_valid_d;
      rd_seen_q   <= rd_seen_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  // The memory read register has no reset, so rd_data is forced to zero until
  // the first pop after reset.
  assign rd_data      = rd_seen_q ? mem_rdata : '0;
  assign rd_valid     = rd_valid_q;
  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl (WIDTH=8, DEPTH=8): queue-based model
// compared every cycle, plus directed literal checks and a randomized phase.
module tb_sync_fifo_ctrl;

  localparam int DEPTH  = 8;
  localparam int AFULL  = DEPTH - 2;
  localparam int AEMPTY = 2;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [7:0] model_q [$];
  logic       exp_rd_valid;
  logic [7:0] exp_rd_data;
  logic       exp_ovf;
  logic       exp_udf;
  bit         m_full, m_empty;
  bit         sticky;

  sync_fifo_ctrl #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of requests at a falling edge; returns at the next falling edge,
  // when that cycle's results are visible.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(negedge clk);
  endtask

  // Reference model: a queue of stored words updated from the requests seen at each edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_q.delete();
        exp_rd_valid = 1'b0;
        exp_rd_data  = 8'h00;
        exp_ovf      = 1'b0;
        exp_udf      = 1'b0;
      end else begin
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        if (rd_en && !m_empty) begin
          exp_rd_data  = model_q.pop_front();
          exp_rd_valid = 1'b1;
        end else begin
          exp_rd_valid = 1'b0;
        end
        if (wr_en && !m_full) begin
          model_q.push_back(wr_data);
        end
        if (sticky) begin
          exp_ovf = exp_ovf | (wr_en && m_full);
          exp_udf = exp_udf | (rd_en && m_empty);
        end else begin
          exp_ovf = wr_en && m_full;
          exp_udf = rd_en && m_empty;
        end
      end
    end
  end

  initial begin
    #2;
    forever begin
      @(negedge clk);
      checkOutput("m_count",        32'(count),        32'(model_q.size()));
      checkOutput("m_full",         32'(full),         32'(model_q.size() == DEPTH));
      checkOutput("m_empty",        32'(empty),        32'(model_q.size() == 0));
      checkOutput("m_almost_full",  32'(almost_full),  32'(model_q.size() >= AFULL));
      checkOutput("m_almost_empty", 32'(almost_empty), 32'(model_q.size() <= AEMPTY));
      checkOutput("m_rd_valid",     32'(rd_valid),     32'(exp_rd_valid));
      checkOutput("m_rd_data",      32'(rd_data),      32'(exp_rd_data));
      checkOutput("m_overflow",     32'(overflow),     32'(exp_ovf));
      checkOutput("m_underflow",    32'(underflow),    32'(exp_udf));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wbias;
    int rbias;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    sticky = 1'b1;
`else
    sticky = 1'b0;
`endif
    rst_n   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_count",        32'(count),        32'd0);
    checkOutput("reset_empty",        32'(empty),        32'd1);
    checkOutput("reset_full",         32'(full),         32'd0);
    checkOutput("reset_almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("reset_almost_full",  32'(almost_full),  32'd0);
    checkOutput("reset_rd_valid",     32'(rd_valid),     32'd0);
    checkOutput("reset_rd_data",      32'(rd_data),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill with 0x10..0x17, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
      checkOutput("t1_count", 32'(count), 32'(i + 1));
      checkOutput("t1_almost_full", 32'(almost_full), 32'(i + 1 >= 6));
      checkOutput("t1_full", 32'(full), 32'(i == 7));
    end
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("t1_rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("t1_rd_data", 32'(rd_data), 32'(8'h10 + i));
    end
    checkOutput("t1_empty", 32'(empty), 32'd1);

    // Overflow while full; write+read while full pops head and drops the write.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0);
    checkOutput("t2_count", 32'(count), 32'd8);
    checkOutput("t2_overflow", 32'(overflow), 32'd1);
    applyStimulus(1'b1, 8'hAA, 1'b1);
    checkOutput("t2_pop_data", 32'(rd_data), 32'h20);
    checkOutput("t2_pop_count", 32'(count), 32'd7);
    for (int i = 1; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("t2_drain", 32'(rd_data), 32'(8'h20 + i));
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t2_overflow_after", 32'(overflow), sticky ? 32'd1 : 32'd0);

    // Write+read on empty: only the write is accepted.
    applyStimulus(1'b1, 8'h5C, 1'b1);
    checkOutput("t3_count", 32'(count), 32'd1);
    checkOutput("t3_rd_valid", 32'(rd_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t3_rd_valid2", 32'(rd_valid), 32'd1);
    checkOutput("t3_rd_data", 32'(rd_data), 32'h5C);

    // Steady state at count=4 with pointers wrapping.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b1);
      checkOutput("t4_count", 32'(count), 32'd4);
      checkOutput("t4_rd_data", 32'(rd_data), (i < 4) ? 32'(8'h30 + i) : 32'(8'h40 + i - 4));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("t4_drain", 32'(rd_data), 32'(8'h50 + i));
    end

    // Read on empty.
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t6_underflow", 32'(underflow), 32'd1);
    checkOutput("t6_rd_valid", 32'(rd_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t6_underflow_after", 32'(underflow), sticky ? 32'd1 : 32'd0);

    // Randomized traffic with varying fill pressure.
    for (int phase = 0; phase < 4; phase++) begin
      wbias = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
      rbias = (phase == 0) ? 30 : (phase == 1) ? 85 : 50;
      for (int i = 0; i < 100; i++) begin
        applyStimulus(1'($urandom_range(99, 0) < 32'(wbias)), 8'($urandom),
                      1'($urandom_range(99, 0) < 32'(rbias)));
      end
    end
    for (int i = 0; i < DEPTH + 1 && model_q.size() > 0; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-burst at count=5.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0);
    checkOutput("t5_count_before", 32'(count), 32'd5);
    wr_en   = 1'b1;
    wr_data = 8'h66;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_count", 32'(count), 32'd0);
    checkOutput("t5_empty", 32'(empty), 32'd1);
    checkOutput("t5_full", 32'(full), 32'd0);
    checkOutput("t5_almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("t5_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("t5_rd_data", 32'(rd_data), 32'd0);
    checkOutput("t5_overflow", 32'(overflow), 32'd0);
    checkOutput("t5_underflow", 32'(underflow), 32'd0);
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t5_read_after_reset", 32'(rd_valid), 32'd0);
    applyStimulus(1'b1, 8'h77, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t5_new_word", 32'(rd_data), 32'h77);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
